// File: rtl/sdcard_perf_pkg.sv
// Shared types and constants for the SD card multi-channel performance monitor.
package sdcard_perf_pkg;

   typedef enum logic {
      PERF_CUMULATIVE = 1'b0,
      PERF_WINDOWED   = 1'b1
   } perf_mode_e;

   // Read-port indices beyond the channels, each added to NUM_CH.
   localparam int IDX_IDLE_OFS = 0;
   localparam int IDX_FIFO_OFS = 1;
   localparam int IDX_PWR_OFS  = 2;

   function automatic int perf_sel_w(input int num_ch);
      return $clog2(num_ch + 3);
   endfunction

endpackage

// File: rtl/sdcard_perf_sat_counter.sv
// Saturating event counter with restart, sticky overflow and a look-ahead next value.
module sdcard_perf_sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clear,
   input  logic         i_restart,
   input  logic         i_inc,
   output logic [W-1:0] o_value,
   output logic [W-1:0] o_next_value,
   output logic         o_ovf
);

   logic [W-1:0] r_value;
   logic         r_ovf;
   logic         w_full;
   logic [W-1:0] w_next;

   assign w_full = &r_value;
   assign w_next = (i_inc && !w_full) ? r_value + {{(W-1){1'b0}}, 1'b1} : r_value;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_value <= '0;
         r_ovf   <= 1'b0;
      end else begin
         // Restart drops the value but still records a saturating hit this cycle.
         r_value <= i_restart ? '0 : w_next;
         if (i_inc && w_full)
            r_ovf <= 1'b1;
      end
   end

   assign o_value      = r_value;
   assign o_next_value = w_next;
   assign o_ovf        = r_ovf;

endmodule

// File: rtl/sdcard_perf_monitor_mc.sv
// Multi-channel SD card performance monitor: busy/idle/power counters, FIFO
// occupancy average, windowed snapshots and an indexed registered read port.
module sdcard_perf_monitor_mc
   import sdcard_perf_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int CNT_W    = 16,
   parameter int FIFO_W   = 10,
   parameter int WIN_LOG2 = 10,
   localparam int SEL_W   = perf_sel_w(NUM_CH)
) (
   input  logic              PCLK_i,
   input  logic              PRESET_i,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              freeze_i,
   input  logic              mode_i,
   input  logic [NUM_CH-1:0] busy_i,
   input  logic [FIFO_W-1:0] fifo_count_i,
   input  logic [1:0]        power_state_i,
   input  logic [SEL_W-1:0]  rd_sel_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic              window_done_o,
   output logic [NUM_CH+1:0] overflow_o,
   output logic              any_overflow_o
);

   localparam int NCNT  = NUM_CH + 2;
   localparam int ACC_W = FIFO_W + WIN_LOG2;

   logic                       w_active;
   logic                       w_term;
   logic                       w_snap;
   logic                       w_restart;
   logic [NCNT-1:0]            w_inc;
   logic [NCNT-1:0]            w_ovf;
   logic [NCNT-1:0][CNT_W-1:0] w_val;
   logic [NCNT-1:0][CNT_W-1:0] w_nxt;
   logic [ACC_W-1:0]           w_acc_next;
   logic [FIFO_W-1:0]          w_avg_full;
   logic [CNT_W-1:0]           w_avg;
   logic [CNT_W-1:0]           w_rd;
   int                         w_sel;

   logic [WIN_LOG2-1:0]        r_timer;
   logic [ACC_W-1:0]           r_acc;
   logic [1:0]                 r_prev_power;
   perf_mode_e                 r_mode;
   logic [NCNT-1:0][CNT_W-1:0] r_snap;
   logic [CNT_W-1:0]           r_avg;
   logic [CNT_W-1:0]           r_rd;
   logic                       r_done;

   assign w_active  = enable_i && !freeze_i;
   assign w_term    = w_active && (&r_timer);
   assign w_snap    = w_term && !clear_i;
   assign w_restart = w_snap && (r_mode == PERF_WINDOWED);

   assign w_inc[NUM_CH-1:0] = busy_i & {NUM_CH{w_active}};
   assign w_inc[NUM_CH]     = w_active && (busy_i == '0);
   assign w_inc[NUM_CH+1]   = w_active && (power_state_i != r_prev_power);

   for (genvar g = 0; g < NCNT; g++) begin : g_cnt
      sdcard_perf_sat_counter #(.W(CNT_W)) u_cnt (
         .i_clk        (PCLK_i),
         .i_rst        (PRESET_i),
         .i_clear      (clear_i),
         .i_restart    (w_restart),
         .i_inc        (w_inc[g]),
         .o_value      (w_val[g]),
         .o_next_value (w_nxt[g]),
         .o_ovf        (w_ovf[g])
      );
   end

   // Terminal-cycle sample is included so the average covers the full window.
   assign w_acc_next = r_acc + {{WIN_LOG2{1'b0}}, fifo_count_i};
   assign w_avg_full = w_acc_next[ACC_W-1:WIN_LOG2];

   if (CNT_W > FIFO_W) begin : g_avg_ext
      assign w_avg = {{(CNT_W-FIFO_W){1'b0}}, w_avg_full};
   end else if (CNT_W == FIFO_W) begin : g_avg_eq
      assign w_avg = w_avg_full;
   end else begin : g_avg_trunc
      assign w_avg = w_avg_full[CNT_W-1:0];
   end

   always_ff @(posedge PCLK_i) begin
      if (PRESET_i || clear_i) begin
         r_timer      <= '0;
         r_acc        <= '0;
         r_prev_power <= 2'b00;
         r_mode       <= perf_mode_e'(mode_i);
         r_snap       <= '0;
         r_avg        <= '0;
         r_done       <= 1'b0;
      end else begin
         r_prev_power <= power_state_i;
         r_done       <= w_snap;
         if (w_active) begin
            r_timer <= r_timer + {{(WIN_LOG2-1){1'b0}}, 1'b1};
            r_acc   <= w_snap ? '0 : w_acc_next;
         end
         if (w_snap) begin
            r_snap <= w_nxt;
            r_avg  <= w_avg;
            r_mode <= perf_mode_e'(mode_i);
         end
      end
   end

   assign w_sel = int'(rd_sel_i);

   always_comb begin
      w_rd = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (w_sel == k) w_rd = r_snap[k];
      if (w_sel == NUM_CH + IDX_IDLE_OFS) w_rd = r_snap[NUM_CH];
      if (w_sel == NUM_CH + IDX_FIFO_OFS) w_rd = r_avg;
      if (w_sel == NUM_CH + IDX_PWR_OFS)  w_rd = r_snap[NUM_CH+1];
   end

   always_ff @(posedge PCLK_i) begin
      if (PRESET_i || clear_i) r_rd <= '0;
      else                     r_rd <= w_rd;
   end

   assign rd_data_o      = r_rd;
   assign window_done_o  = r_done;
   assign overflow_o     = w_ovf;
   assign any_overflow_o = |w_ovf;

endmodule

// File: tb/tb_sdcard_perf_monitor_mc.sv
// Directed bench for sdcard_perf_monitor_mc (NUM_CH=3, CNT_W=8, WIN_LOG2=4).
module tb_sdcard_perf_monitor_mc;

   logic       PCLK_i = 1'b0;
   logic       PRESET_i;
   logic       enable_i, clear_i, freeze_i, mode_i;
   logic [2:0] busy_i;
   logic [9:0] fifo_count_i;
   logic [1:0] power_state_i;
   logic [2:0] rd_sel_i;
   logic [7:0] rd_data_o;
   logic       window_done_o;
   logic [4:0] overflow_o;
   logic       any_overflow_o;

   int n_chk = 0;
   int n_err = 0;
   int p, f;

   sdcard_perf_monitor_mc #(.NUM_CH(3), .CNT_W(8), .FIFO_W(10), .WIN_LOG2(4)) u_dut (
      .PCLK_i(PCLK_i), .PRESET_i(PRESET_i), .enable_i(enable_i), .clear_i(clear_i),
      .freeze_i(freeze_i), .mode_i(mode_i), .busy_i(busy_i), .fifo_count_i(fifo_count_i),
      .power_state_i(power_state_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
      .window_done_o(window_done_o), .overflow_o(overflow_o), .any_overflow_o(any_overflow_o)
   );

   always #5 PCLK_i = ~PCLK_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK_i);
      #1;
   endtask

   task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string tag);
      rd_sel_i = sel;
      step();
      chk(tag, {24'd0, rd_data_o}, exp);
   endtask

   // Enabled for n cycles; reports the pulse count and the cycle of the first pulse.
   task automatic run(input int n, output int pulses, output int first);
      pulses = 0;
      first  = -1;
      enable_i = 1'b1;
      for (int i = 1; i <= n; i++) begin
         step();
         if (window_done_o) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      enable_i = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
   endtask

   initial begin
      int pseq [5] = '{0, 1, 2, 2, 0};
      PRESET_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; freeze_i = 1'b0; mode_i = 1'b1;
      busy_i = 3'b000; fifo_count_i = 10'd0; power_state_i = 2'd0; rd_sel_i = 3'd0;
      step(); step();
      PRESET_i = 1'b0;
      step();
      chk("rst_rd", {24'd0, rd_data_o}, 0);
      chk("rst_done", {31'd0, window_done_o}, 0);
      chk("rst_ovf", {27'd0, overflow_o}, 0);

      // Window of channel-0 activity in windowed mode
      busy_i = 3'b001;
      run(16, p, f);
      chk("w1_pulses", p, 1);
      chk("w1_first", f, 16);
      busy_i = 3'b000;
      step();
      chk("w1_done_drop", {31'd0, window_done_o}, 0);
      rd(3'd0, 16, "w1_sel0");
      rd(3'd1, 0, "w1_sel1");
      rd(3'd3, 0, "w1_idle");
      chk("w1_anyovf", {31'd0, any_overflow_o}, 0);

      // Idle windows with constant FIFO occupancy, twice to prove restart
      fifo_count_i = 10'd10;
      for (int w = 0; w < 2; w++) begin
         run(16, p, f);
         chk("w2_pulses", p, 1);
         rd(3'd4, 10, "w2_avg");
         rd(3'd3, 16, "w2_idle");
         rd(3'd0, 0, "w2_sel0");
      end
      fifo_count_i = 10'd0;

      // Cumulative mode saturation on channel 2
      mode_i = 1'b0;
      pulse_clear();
      busy_i = 3'b100;
      run(300, p, f);
      chk("sat_pulses", p, 18);
      busy_i = 3'b000;
      rd(3'd2, 255, "sat_sel2");
      chk("sat_ovf", {27'd0, overflow_o}, 32'h04);
      chk("sat_anyovf", {31'd0, any_overflow_o}, 1);
      step(); step();
      chk("sat_sticky", {27'd0, overflow_o}, 32'h04);
      pulse_clear();
      chk("clr_ovf", {27'd0, overflow_o}, 0);
      chk("clr_rd", {24'd0, rd_data_o}, 0);
      rd(3'd2, 0, "clr_sel2");
      rd(3'd3, 0, "clr_idle");

      // Power transitions, cumulative mode
      enable_i = 1'b1;
      p = 0;
      for (int i = 0; i < 16; i++) begin
         power_state_i = (i < 5) ? 2'(pseq[i]) : 2'd0;
         step();
         if (window_done_o) p++;
      end
      enable_i = 1'b0;
      chk("pwr_pulses", p, 1);
      rd(3'd5, 3, "pwr_sel5");
      rd(3'd3, 16, "pwr_idle1");
      power_state_i = 2'd1; step();
      power_state_i = 2'd2; step();
      run(16, p, f);
      rd(3'd5, 3, "pwr_noextra");
      rd(3'd3, 32, "pwr_idle_cum");
      power_state_i = 2'd0;

      // Freeze mid-window, windowed mode
      mode_i = 1'b1;
      pulse_clear();
      busy_i = 3'b111;
      run(8, p, f);
      chk("frz_pre", p, 0);
      enable_i = 1'b1; freeze_i = 1'b1;
      p = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (window_done_o) p++;
      end
      freeze_i = 1'b0;
      chk("frz_hold", p, 0);
      run(8, p, f);
      chk("frz_pulses", p, 1);
      chk("frz_first", f, 8);
      busy_i = 3'b000;
      rd(3'd0, 16, "frz_sel0");
      rd(3'd1, 16, "frz_sel1");
      rd(3'd2, 16, "frz_sel2");
      rd(3'd3, 0, "frz_idle");

      // Clear in the terminal cycle wins over the snapshot
      busy_i = 3'b001;
      run(15, p, f);
      chk("tc_pre", p, 0);
      enable_i = 1'b1; clear_i = 1'b1;
      step();
      chk("tc_done", {31'd0, window_done_o}, 0);
      enable_i = 1'b0; clear_i = 1'b0;
      step();
      chk("tc_done2", {31'd0, window_done_o}, 0);
      rd(3'd0, 0, "tc_sel0");
      rd(3'd1, 0, "tc_sel1");
      run(16, p, f);
      chk("tc_next_first", f, 16);
      busy_i = 3'b000;
      rd(3'd0, 16, "tc_next_sel0");
      rd(3'd7, 0, "unused_sel7");
      rd(3'd6, 0, "unused_sel6");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
